// File: rtl/pong_pkg.sv
// Shared playfield geometry and FSM state type for the pong game controller.
package pong_pkg;

   localparam int unsigned GRID_W   = 40;
   localparam int unsigned GRID_H   = 30;
   localparam int unsigned CENTER_X = 20;
   localparam int unsigned CENTER_Y = 15;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

endpackage

// File: rtl/pong_ball_step.sv
// One ball step: wall reflection, paddle deflection and miss detection (pure combinational).
module pong_ball_step
   import pong_pkg::*;
#(
   parameter int unsigned P1_X     = 0,
   parameter int unsigned P2_X     = 37,
   parameter int unsigned PADDLE_H = 6
) (
   input  logic [5:0] i_x,
   input  logic [5:0] i_y,
   input  logic       i_dx_pos,
   input  logic       i_dy_pos,
   input  logic [5:0] i_paddle1_y,
   input  logic [5:0] i_paddle2_y,
   output logic [5:0] o_x,
   output logic [5:0] o_y,
   output logic       o_dx_pos,
   output logic       o_dy_pos,
   output logic       o_miss_left,
   output logic       o_miss_right
);

   logic       w_flip_y;
   logic       w_dy_pos;
   logic       w_dx_pos;
   logic       w_hit_left;
   logic       w_hit_right;
   logic [6:0] w_y7;
   logic [6:0] w_p1_lo;
   logic [6:0] w_p1_hi;
   logic [6:0] w_p2_lo;
   logic [6:0] w_p2_hi;

   // Paddle span is widened to 7 bits so a paddle near the bottom never wraps.
   assign w_y7    = {1'b0, i_y};
   assign w_p1_lo = {1'b0, i_paddle1_y};
   assign w_p1_hi = w_p1_lo + 7'(PADDLE_H - 1);
   assign w_p2_lo = {1'b0, i_paddle2_y};
   assign w_p2_hi = w_p2_lo + 7'(PADDLE_H - 1);

   assign o_miss_left  = !i_dx_pos && (i_x == 6'd0);
   assign o_miss_right = i_dx_pos && (i_x == 6'(GRID_W - 1));

   assign w_flip_y = (i_y == 6'd0 && !i_dy_pos) || (i_y == 6'(GRID_H - 1) && i_dy_pos);
   assign w_dy_pos = i_dy_pos ^ w_flip_y;

   assign w_hit_left  = !i_dx_pos && (i_x == 6'(P1_X + 1)) &&
                        (w_y7 >= w_p1_lo) && (w_y7 <= w_p1_hi);
   assign w_hit_right = i_dx_pos && (i_x == 6'(P2_X - 1)) &&
                        (w_y7 >= w_p2_lo) && (w_y7 <= w_p2_hi);
   assign w_dx_pos    = i_dx_pos ^ (w_hit_left | w_hit_right);

   always_comb begin
      o_x      = i_x;
      o_y      = i_y;
      o_dx_pos = i_dx_pos;
      o_dy_pos = i_dy_pos;
      if (!(o_miss_left || o_miss_right)) begin
         o_dx_pos = w_dx_pos;
         o_dy_pos = w_dy_pos;
         o_x      = w_dx_pos ? i_x + 6'd1 : i_x - 6'd1;
         o_y      = w_dy_pos ? i_y + 6'd1 : i_y - 6'd1;
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/score FSM with registered ball position and scores.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned P1_X         = 0,
   parameter int unsigned P2_X         = 37,
   parameter int unsigned PADDLE_H     = 6,
   parameter int unsigned MOVE_DIV     = 4,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [5:0] paddle1_y,
   input  logic [5:0] paddle2_y,
   output logic [5:0] ball_x,
   output logic [5:0] ball_y,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       ball_en,
   output logic       game_over
);

   state_t      r_state, w_state_n;
   logic [5:0]  r_x, w_x_n, r_y, w_y_n;
   logic        r_dx, w_dx_n, r_dy, w_dy_n, r_serve_dir, w_serve_dir_n;
   logic        r_p1_scored, w_p1_scored_n, r_ball_en, r_game_over;
   logic [3:0]  r_score1, w_score1_n, r_score2, w_score2_n, w_s1_inc, w_s2_inc;
   logic [15:0] r_serve_cnt, w_serve_cnt_n;
   logic [7:0]  r_step_cnt, w_step_cnt_n;
   logic [5:0]  w_step_x, w_step_y;
   logic        w_step_dx, w_step_dy, w_miss_left, w_miss_right, w_win;

   pong_ball_step #(
      .P1_X     (P1_X),
      .P2_X     (P2_X),
      .PADDLE_H (PADDLE_H)
   ) u_ball_step (
      .i_x          (r_x),
      .i_y          (r_y),
      .i_dx_pos     (r_dx),
      .i_dy_pos     (r_dy),
      .i_paddle1_y  (paddle1_y),
      .i_paddle2_y  (paddle2_y),
      .o_x          (w_step_x),
      .o_y          (w_step_y),
      .o_dx_pos     (w_step_dx),
      .o_dy_pos     (w_step_dy),
      .o_miss_left  (w_miss_left),
      .o_miss_right (w_miss_right)
   );

   assign w_s1_inc = (r_score1 < 4'(WIN_SCORE)) ? r_score1 + 4'd1 : r_score1;
   assign w_s2_inc = (r_score2 < 4'(WIN_SCORE)) ? r_score2 + 4'd1 : r_score2;
   assign w_win    = r_p1_scored ? (w_s1_inc == 4'(WIN_SCORE)) : (w_s2_inc == 4'(WIN_SCORE));

   always_comb begin
      w_state_n     = r_state;
      w_x_n         = r_x;
      w_y_n         = r_y;
      w_dx_n        = r_dx;
      w_dy_n        = r_dy;
      w_serve_dir_n = r_serve_dir;
      w_p1_scored_n = r_p1_scored;
      w_score1_n    = r_score1;
      w_score2_n    = r_score2;
      w_serve_cnt_n = r_serve_cnt;
      w_step_cnt_n  = r_step_cnt;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_n     = SERVE;
               w_serve_dir_n = 1'b1;
               w_serve_cnt_n = '0;
               w_step_cnt_n  = '0;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (r_serve_cnt == 16'(SERVE_FRAMES - 1)) begin
                  w_state_n     = PLAY;
                  w_dx_n        = r_serve_dir;
                  w_dy_n        = 1'b1;
                  w_serve_cnt_n = '0;
               end else begin
                  w_serve_cnt_n = r_serve_cnt + 16'd1;
               end
            end
         end
         PLAY: begin
            if (frame_tick) begin
               if (r_step_cnt == 8'(MOVE_DIV - 1)) begin
                  w_step_cnt_n = '0;
                  if (w_miss_left || w_miss_right) begin
                     w_state_n     = POINT;
                     w_p1_scored_n = w_miss_right;
                  end else begin
                     w_x_n  = w_step_x;
                     w_y_n  = w_step_y;
                     w_dx_n = w_step_dx;
                     w_dy_n = w_step_dy;
                  end
               end else begin
                  w_step_cnt_n = r_step_cnt + 8'd1;
               end
            end
         end
         POINT: begin
            // Serve heads toward whoever just lost the point.
            w_serve_dir_n = r_p1_scored;
            if (r_p1_scored) w_score1_n = w_s1_inc;
            else             w_score2_n = w_s2_inc;
            w_x_n         = 6'(CENTER_X);
            w_y_n         = 6'(CENTER_Y);
            w_serve_cnt_n = '0;
            w_step_cnt_n  = '0;
            w_state_n     = w_win ? OVER : SERVE;
         end
         OVER: begin
            if (start) begin
               w_state_n     = SERVE;
               w_score1_n    = '0;
               w_score2_n    = '0;
               w_serve_dir_n = 1'b1;
               w_serve_cnt_n = '0;
               w_step_cnt_n  = '0;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x         <= 6'(CENTER_X);
         r_y         <= 6'(CENTER_Y);
         r_dx        <= 1'b1;
         r_dy        <= 1'b1;
         r_serve_dir <= 1'b1;
         r_p1_scored <= 1'b0;
         r_score1    <= '0;
         r_score2    <= '0;
         r_serve_cnt <= '0;
         r_step_cnt  <= '0;
         r_ball_en   <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_x         <= w_x_n;
         r_y         <= w_y_n;
         r_dx        <= w_dx_n;
         r_dy        <= w_dy_n;
         r_serve_dir <= w_serve_dir_n;
         r_p1_scored <= w_p1_scored_n;
         r_score1    <= w_score1_n;
         r_score2    <= w_score2_n;
         r_serve_cnt <= w_serve_cnt_n;
         r_step_cnt  <= w_step_cnt_n;
         r_ball_en   <= (w_state_n == SERVE) || (w_state_n == PLAY) || (w_state_n == POINT);
         r_game_over <= (w_state_n == OVER);
      end
   end

   assign ball_x    = r_x;
   assign ball_y    = r_y;
   assign score1    = r_score1;
   assign score2    = r_score2;
   assign ball_en   = r_ball_en;
   assign game_over = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Random-stimulus bench for pong_game_ctrl against an integer game model.
module tb_pong_game_ctrl;

   localparam int P1X = 0;
   localparam int P2X = 37;
   localparam int PH  = 6;
   localparam int MD  = 4;
   localparam int SF  = 60;
   localparam int WS  = 9;

   localparam int M_IDLE  = 0;
   localparam int M_SERVE = 1;
   localparam int M_PLAY  = 2;
   localparam int M_POINT = 3;
   localparam int M_OVER  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic [5:0] paddle1_y = '0;
   logic [5:0] paddle2_y = '0;
   logic [5:0] ball_x, ball_y;
   logic [3:0] score1, score2;
   logic       ball_en, game_over;

   int n_checks = 0;
   int n_errors = 0;

   // Game model: plain integers, velocities as -1/+1.
   int m_mode, m_x, m_y, m_vx, m_vy, m_s1, m_s2, m_dir, m_ticks, m_steps, m_scorer;

   always #5 clk = ~clk;

   pong_game_ctrl #(
      .P1_X         (P1X),
      .P2_X         (P2X),
      .PADDLE_H     (PH),
      .MOVE_DIV     (MD),
      .SERVE_FRAMES (SF),
      .WIN_SCORE    (WS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .start      (start),
      .paddle1_y  (paddle1_y),
      .paddle2_y  (paddle2_y),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .score1     (score1),
      .score2     (score2),
      .ball_en    (ball_en),
      .game_over  (game_over)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
      n_checks++;
      if (obs !== 32'(exp)) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_x = 20; m_y = 15; m_vx = 1; m_vy = 1;
      m_s1 = 0; m_s2 = 0; m_dir = 1; m_ticks = 0; m_steps = 0; m_scorer = 0;
   endtask

   task automatic model_move(input int p1, input int p2);
      if (m_vx < 0 && m_x == 0) begin
         m_mode = M_POINT; m_scorer = 2;
      end else if (m_vx > 0 && m_x == 39) begin
         m_mode = M_POINT; m_scorer = 1;
      end else begin
         if ((m_y == 0 && m_vy < 0) || (m_y == 29 && m_vy > 0)) m_vy = -m_vy;
         if (m_vx < 0 && m_x == P1X + 1 && m_y >= p1 && m_y <= p1 + PH - 1) m_vx = 1;
         else if (m_vx > 0 && m_x == P2X - 1 && m_y >= p2 && m_y <= p2 + PH - 1) m_vx = -1;
         m_x = m_x + m_vx;
         m_y = m_y + m_vy;
      end
   endtask

   task automatic model_clock(input bit r, input bit s, input bit t, input int p1, input int p2);
      if (r) begin
         model_reset();
      end else begin
         case (m_mode)
            M_IDLE: if (s) begin m_mode = M_SERVE; m_dir = 1; m_ticks = 0; end
            M_SERVE: if (t) begin
               m_ticks++;
               if (m_ticks == SF) begin
                  m_mode = M_PLAY; m_vx = m_dir; m_vy = 1; m_steps = 0;
               end
            end
            M_PLAY: if (t) begin
               m_steps++;
               if (m_steps == MD) begin m_steps = 0; model_move(p1, p2); end
            end
            M_POINT: begin
               if (m_scorer == 1) begin m_s1 = (m_s1 < WS) ? m_s1 + 1 : m_s1; m_dir = 1; end
               else               begin m_s2 = (m_s2 < WS) ? m_s2 + 1 : m_s2; m_dir = -1; end
               m_x = 20; m_y = 15; m_ticks = 0;
               m_mode = (m_s1 == WS || m_s2 == WS) ? M_OVER : M_SERVE;
            end
            M_OVER: if (s) begin
               m_s1 = 0; m_s2 = 0; m_dir = 1; m_ticks = 0; m_mode = M_SERVE;
            end
            default: m_mode = M_IDLE;
         endcase
      end
   endtask

   task automatic compare_all();
      check_val("ball_x", 32'(ball_x), m_x);
      check_val("ball_y", 32'(ball_y), m_y);
      check_val("score1", 32'(score1), m_s1);
      check_val("score2", 32'(score2), m_s2);
      check_val("ball_en", 32'(ball_en),
                (m_mode == M_SERVE || m_mode == M_PLAY || m_mode == M_POINT) ? 1 : 0);
      check_val("game_over", 32'(game_over), (m_mode == M_OVER) ? 1 : 0);
   endtask

   task automatic cycle(input bit r, input bit s, input bit t, input int p1, input int p2);
      rst = r; start = s; frame_tick = t;
      paddle1_y = 6'(p1); paddle2_y = 6'(p2);
      @(posedge clk);
      model_clock(r, s, t, p1, p2);
      #1;
      compare_all();
   endtask

   function automatic int pick_paddle();
      int p;
      case ($urandom_range(0, 3))
         0: p = $urandom_range(0, 29);
         1: p = $urandom_range(24, 29);
         default: begin
            p = m_y - int'($urandom_range(0, PH - 1));
            if (p < 0) p = 0;
         end
      endcase
      return p;
   endfunction

   initial begin
      int guard;
      model_reset();
      cycle(1, 1, 1, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check_val("rst_x", 32'(ball_x), 20);
      check_val("rst_y", 32'(ball_y), 15);
      check_val("rst_en", 32'(ball_en), 0);

      cycle(0, 1, 0, 0, 0);
      check_val("serve_en", 32'(ball_en), 1);
      for (int i = 0; i < SF; i++) begin
         cycle(0, 0, 1, 0, 0);
         cycle(0, 0, 0, 0, 0);
      end
      check_val("play_hold_x", 32'(ball_x), 20);
      check_val("play_hold_y", 32'(ball_y), 15);
      for (int i = 0; i < MD - 1; i++) begin
         cycle(0, 0, 1, 0, 0);
         cycle(0, 0, 0, 0, 0);
         check_val("pre_step_x", 32'(ball_x), 20);
      end
      cycle(0, 0, 1, 0, 0);
      check_val("first_step_x", 32'(ball_x), 21);
      check_val("first_step_y", 32'(ball_y), 16);

      for (int i = 0; i < 60000 && n_errors < 50; i++) begin
         cycle(($urandom_range(0, 3999) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 3) != 0), pick_paddle(), pick_paddle());
      end

      // Reach PLAY, then reset together with start and frame_tick.
      guard = 0;
      while (m_mode != M_PLAY && guard < 3000) begin
         cycle(0, 1, 1, 0, 0);
         guard++;
      end
      check_val("reach_play", 32'(m_mode), M_PLAY);
      cycle(0, 0, 1, pick_paddle(), pick_paddle());
      cycle(1, 1, 1, 0, 0);
      check_val("midplay_rst_x", 32'(ball_x), 20);
      check_val("midplay_rst_y", 32'(ball_y), 15);
      check_val("midplay_rst_s1", 32'(score1), 0);
      check_val("midplay_rst_s2", 32'(score2), 0);
      check_val("midplay_rst_en", 32'(ball_en), 0);
      cycle(0, 0, 1, 0, 0);
      check_val("idle_stays", 32'(ball_en), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter P1_X, default 0, meaning left paddle column in 16-px cells.
REQ-002 SHALL have parameter P2_X, default 37, meaning right paddle column.
REQ-003 SHALL have parameter PADDLE_H, default 6, meaning paddle height in cells.
REQ-004 SHALL have parameter MOVE_DIV, default 4, meaning frame ticks per ball step.
REQ-005 SHALL have parameter SERVE_FRAMES, default 60, meaning frame ticks held in SERVE.
REQ-006 SHALL have parameter WIN_SCORE, default 9, meaning points that end the game.
REQ-007 SHALL have ports clk (in, 1, 25 MHz pixel clock) and rst (in, 1, synchronous active-high reset); one clock only.
REQ-008 SHALL have port frame_tick (in, 1): single-cycle pulse, once per frame.
REQ-009 SHALL have port start (in, 1): level, start/restart request.
REQ-010 SHALL have ports paddle1_y and paddle2_y (in, 6 each): paddle top row, 0..29.
REQ-011 SHALL have ports ball_x (out, 6, column 0..39) and ball_y (out, 6, row 0..29).
REQ-012 SHALL have ports score1 and score2 (out, 4 each): player scores.
REQ-013 SHALL have ports ball_en (out, 1, ball drawable) and game_over (out, 1).

Function
REQ-014 SHALL implement FSM states IDLE, SERVE, PLAY, POINT, OVER.
REQ-015 IDLE: ball at (20,15), ball_en=0; start=1 -> SERVE next cycle, serve direction right.
REQ-016 SERVE: ball held at (20,15), ball_en=1; counts frame_tick; after SERVE_FRAMES ticks -> PLAY, dy=+1, dx = serve direction.
REQ-017 PLAY: step counter counts frame_tick modulo MOVE_DIV; step fires on the tick completing each MOVE_DIV count; ball_x/ball_y update the cycle after that tick.
REQ-018 Y reflect: if (y==0 and dy=-1) or (y==29 and dy=+1), dy flips before move; y_next = y + new dy.
REQ-019 Left hit: dx=-1, x==P1_X+1, paddle1_y <= y <= paddle1_y+PADDLE_H-1 -> dx flips to +1; x_next = x+1.
REQ-020 Right hit: dx=+1, x==P2_X-1, paddle2_y <= y <= paddle2_y+PADDLE_H-1 -> dx flips to -1; x_next = x-1.
REQ-021 Miss: dx=-1 and x==0 -> POINT for player 2; dx=+1 and x==39 -> POINT for player 1; ball does not move on that step.
REQ-022 Corner: y reflect and paddle hit in the same step SHALL both apply.
REQ-023 Paddle range comparison SHALL use 7-bit arithmetic; no wrap when paddle_y+PADDLE_H > 29.
REQ-024 POINT: one cycle; scorer's score +1; serve direction = toward the player who lost the point; score reaching WIN_SCORE -> OVER, else -> SERVE.
REQ-025 OVER: game_over=1, ball_en=0, scores held; start=1 -> scores cleared, serve direction right, -> SERVE.
REQ-026 start SHALL be ignored in SERVE, PLAY, and POINT.
REQ-027 frame_tick arriving in the POINT cycle SHALL be dropped; the step counter clears on every SERVE entry.
REQ-028 Scores SHALL never exceed WIN_SCORE.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst=1 at any clock edge SHALL force IDLE, ball (20,15), dx=+1, dy=+1, scores 0, ball_en=0, game_over=0, counters 0, including mid-PLAY.
REQ-031 rst SHALL take priority over start and frame_tick in the same cycle.

Structure
REQ-032 Package pong_pkg SHALL hold the state enum, GRID_W=40, GRID_H=30, CENTER_X=20, and CENTER_Y=15.
REQ-033 The combinational next-position and collision logic SHALL be isolated in sub-module pong_ball_step.

Verification
REQ-034 rst; start=1 one cycle; 60 ticks -> PLAY at (20,15); 4 more ticks -> ball (21,16) one cycle after the 4th tick.
REQ-035 Ball (1,10), dx=-1, paddle1_y=8 -> next step ball (2,11 or 9 per dy), dx=+1, scores unchanged.
REQ-036 Ball (0,3), dx=-1, paddle1_y=20 -> POINT, score2=1, SERVE at (20,15), serve direction left.
REQ-037 Ball (36,29), dx=+1, dy=+1, paddle2_y=24 -> ball (35,28), dx=-1, dy=-1.
REQ-038 score1=8 plus a right-side miss -> score1=9, game_over=1; start -> scores 0, SERVE.
REQ-039 rst asserted mid-PLAY together with frame_tick -> next cycle IDLE, (20,15), scores 0.
